w5300_bus_arbiter: RTL

// N-channel round-robin arbiter between the config, IRQ and data-path clients and the single W5300 bus interface.

---
 rtl/w5300_bus_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/w5300_bus_arbiter.sv
// rtl/w5300_bus_arbiter.sv - round-robin arbiter with burst lock and timeout onto the single W5300 bus interface
// Holding registers keep if_* stable from ISSUE through WAIT; completion is routed back to the granted channel only.
module w5300_bus_arbiter #(
   parameter int N_CH       = 4,
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 16,
   parameter int CLK_FREQ   = 100,
   parameter int TIMEOUT_US = 60
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_CH-1:0]          ch_req,
   input  logic [N_CH-1:0]          ch_lock,
   input  logic [N_CH-1:0]          ch_we,
   input  logic [N_CH*ADDR_W-1:0]   ch_addr,
   input  logic [N_CH*DATA_W-1:0]   ch_wr_data,
   output logic [N_CH-1:0]          ch_ack,
   output logic [N_CH-1:0]          ch_err,
   output logic [DATA_W-1:0]        ch_rd_data,
   output logic                     if_start,
   output logic                     if_we,
   output logic [ADDR_W-1:0]        if_addr,
   output logic [DATA_W-1:0]        if_wr_data,
   input  logic                     if_done,
   input  logic [DATA_W-1:0]        if_rd_data,
   output logic [$clog2(N_CH)-1:0]  grant_id,
   output logic                     busy,
   output logic [7:0]               err_count
);

   localparam int GW      = $clog2(N_CH);
   localparam int TIMEOUT = TIMEOUT_US * CLK_FREQ;
   localparam int TW      = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK, S_ERR} state_t;

   state_t              state_q, state_d;
   logic [GW-1:0]       last_q, last_d;
   logic [GW-1:0]       grant_q, grant_d;
   logic                lock_q, lock_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rd_q, rd_d;
   logic [7:0]          errcnt_q, errcnt_d;

   logic                found;
   logic [GW-1:0]       pick;
   logic [GW-1:0]       cand;
   int                  idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         last_q   <= GW'(N_CH - 1);
         grant_q  <= '0;
         lock_q   <= 1'b0;
         timer_q  <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rd_q     <= '0;
         errcnt_q <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         grant_q  <= grant_d;
         lock_q   <= lock_d;
         timer_q  <= timer_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rd_q     <= rd_d;
         errcnt_q <= errcnt_d;
      end
   end

   // A held lock beats the rotation; otherwise search starts just after the last grant.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      idx   = 0;
      if (lock_q && ch_req[last_q]) begin
         found = 1'b1;
         pick  = last_q;
      end else begin
         for (int k = 1; k <= N_CH; k++) begin
            idx = int'(last_q) + k;
            if (idx >= N_CH) idx = idx - N_CH;
            cand = GW'(idx);
            if (!found && ch_req[cand]) begin
               found = 1'b1;
               pick  = cand;
            end
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      grant_d  = grant_q;
      lock_d   = lock_q;
      timer_d  = timer_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rd_d     = rd_q;
      errcnt_d = errcnt_q;
      case (state_q)
         S_IDLE: begin
            if (!(lock_q && ch_req[last_q])) lock_d = 1'b0;
            if (found) begin
               grant_d = pick;
               we_d    = ch_we[pick];
               addr_d  = ch_addr[int'(pick)*ADDR_W +: ADDR_W];
               wdata_d = ch_wr_data[int'(pick)*DATA_W +: DATA_W];
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            timer_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            timer_d = timer_q + 1'b1;
            if (if_done) begin
               rd_d    = if_rd_data;
               state_d = S_ACK;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               state_d = S_ERR;
            end
         end
         S_ACK: begin
            last_d  = grant_q;
            lock_d  = ch_lock[grant_q];
            state_d = S_IDLE;
         end
         S_ERR: begin
            if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
            last_d  = grant_q;
            lock_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign if_start   = (state_q == S_ISSUE);
   assign if_we      = we_q;
   assign if_addr    = addr_q;
   assign if_wr_data = wdata_q;
   assign ch_ack     = (state_q == S_ACK) ? ({{(N_CH-1){1'b0}}, 1'b1} << grant_q) : '0;
   assign ch_err     = (state_q == S_ERR) ? ({{(N_CH-1){1'b0}}, 1'b1} << grant_q) : '0;
   assign ch_rd_data = rd_q;
   assign grant_id   = grant_q;
   assign busy       = (state_q != S_IDLE);
   assign err_count  = errcnt_q;

endmodule
